// File: rtl/vmem_pkg.sv
// Shared types and defaults for the unified scalar/vector data memory.
// Holds the sequencer state enum, the default geometry and the lane-select helper.
package vmem_pkg;

  localparam int VMEM_N     = 24;
  localparam int VMEM_AW    = 14;
  localparam int VMEM_LANES = 8;
  localparam int VMEM_BW    = $clog2(VMEM_LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VBUSY = 2'd1,
    VRESP = 2'd2
  } vmem_state_e;

  // Returns the enable bit of the lane currently being sequenced.
  function automatic logic lane_sel(input logic [VMEM_LANES-1:0] mask,
                                    input logic [VMEM_BW-1:0]    beat);
    return mask[beat];
  endfunction

endpackage

// File: rtl/vector_data_memory_if.sv
// Request/response bundle of vector_data_memory.
// req_mask exists only when VMEM_LANE_MASK_EN is defined.
interface vector_data_memory_if
  import vmem_pkg::*;
#(
  parameter int N     = VMEM_N,
  parameter int LANES = VMEM_LANES
);

  logic               req_valid;
  logic               req_ready;
  logic               req_vector;
  logic               req_write;
  logic [N-1:0]       req_addr;
  logic [N-1:0]       req_wdata_s;
  logic [LANES*N-1:0] req_wdata_v;
`ifdef VMEM_LANE_MASK_EN
  logic [LANES-1:0]   req_mask;
`endif
  logic               rsp_valid;
  logic [N-1:0]       rsp_rdata_s;
  logic [LANES*N-1:0] rsp_rdata_v;

`ifdef VMEM_LANE_MASK_EN
  modport master (
    output req_valid, req_vector, req_write, req_addr, req_wdata_s, req_wdata_v, req_mask,
    input  req_ready, rsp_valid, rsp_rdata_s, rsp_rdata_v
  );
  modport slave (
    input  req_valid, req_vector, req_write, req_addr, req_wdata_s, req_wdata_v, req_mask,
    output req_ready, rsp_valid, rsp_rdata_s, rsp_rdata_v
  );
`else
  modport master (
    output req_valid, req_vector, req_write, req_addr, req_wdata_s, req_wdata_v,
    input  req_ready, rsp_valid, rsp_rdata_s, rsp_rdata_v
  );
  modport slave (
    input  req_valid, req_vector, req_write, req_addr, req_wdata_s, req_wdata_v,
    output req_ready, rsp_valid, rsp_rdata_s, rsp_rdata_v
  );
`endif

endinterface

// File: rtl/vmem_sp_ram.sv
// Single-port synchronous RAM with write enable and registered read.
// Contents are never reset; a same-address write returns the old word on that edge.
module vmem_sp_ram
  import vmem_pkg::*;
#(
  parameter int N     = VMEM_N,
  parameter int AW    = VMEM_AW,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [N-1:0]  wdata_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_data_memory.sv
// Unified scalar/vector data memory: scalar accesses in one cycle, vector accesses
// serialized one lane per cycle. Optional lane masking via VMEM_LANE_MASK_EN.
module vector_data_memory
  import vmem_pkg::*;
#(
  parameter int N     = VMEM_N,
  parameter int AW    = VMEM_AW,
  parameter int LANES = VMEM_LANES,
  parameter int DEPTH = 2**AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_data_memory_if.slave  bus
);

  localparam int             BW        = $clog2(LANES);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(LANES-1);

  vmem_state_e        state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [AW-1:0]      base_q;
  logic               wr_q;
  logic [LANES*N-1:0] wdata_v_q;
  logic [LANES*N-1:0] fill_q, fill_d;
  logic [LANES*N-1:0] rdata_v_q;
  logic [N-1:0]       rdata_s_q;
  logic               srsp_q;
  logic               srd_q;
`ifdef VMEM_LANE_MASK_EN
  logic [LANES-1:0]   mask_q;
`endif

  logic          req_ready;
  logic          accept;
  logic          lane_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [N-1:0]  ram_wdata;
  logic [N-1:0]  ram_rdata;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[N-1:AW];

  assign req_ready = rst_n && (state_q != VBUSY);
  assign accept    = bus.req_valid && req_ready;

`ifdef VMEM_LANE_MASK_EN
  assign lane_en = lane_sel(mask_q, beat_q);
`else
  assign lane_en = 1'b1;
`endif

  // Vector reads address one word ahead so each beat sees its own lane on the RAM output.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    ram_we    = 1'b0;
    ram_addr  = bus.req_addr[AW-1:0];
    ram_wdata = bus.req_wdata_s;
    fill_d    = fill_q;
    case (state_q)
      IDLE, VRESP: begin
        state_d = IDLE;
        if (accept) begin
          if (bus.req_vector) begin
            state_d = VBUSY;
            beat_d  = '0;
          end else begin
            ram_we = bus.req_write;
          end
        end
      end
      VBUSY: begin
        ram_addr  = base_q + AW'(beat_q) + AW'(!wr_q);
        ram_we    = wr_q && lane_en;
        ram_wdata = wdata_v_q[beat_q*N +: N];
        fill_d[beat_q*N +: N] = lane_en ? ram_rdata : '0;
        if (beat_q == LAST_BEAT) begin
          state_d = VRESP;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      wr_q      <= 1'b0;
      wdata_v_q <= '0;
      fill_q    <= '0;
      rdata_v_q <= '0;
      rdata_s_q <= '0;
      srsp_q    <= 1'b0;
      srd_q     <= 1'b0;
`ifdef VMEM_LANE_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      srsp_q  <= accept && !bus.req_vector;
      srd_q   <= accept && !bus.req_vector && !bus.req_write;
      if (srd_q) begin
        rdata_s_q <= ram_rdata;
      end
      if (accept && bus.req_vector) begin
        base_q    <= bus.req_addr[AW-1:0];
        wr_q      <= bus.req_write;
        wdata_v_q <= bus.req_wdata_v;
`ifdef VMEM_LANE_MASK_EN
        mask_q    <= bus.req_mask;
`endif
      end
      if ((state_q == VBUSY) && !wr_q) begin
        fill_q <= fill_d;
        if (beat_q == LAST_BEAT) begin
          rdata_v_q <= fill_d;
        end
      end
    end
  end

  // Scalar read data comes straight off the RAM register in its response cycle, then is held.
  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = srsp_q || (state_q == VRESP);
  assign bus.rsp_rdata_s = srd_q ? ram_rdata : rdata_s_q;
  assign bus.rsp_rdata_v = rdata_v_q;

  vmem_sp_ram #(
    .N     (N),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: doc/vector_data_memory.md
# vector_data_memory

Unified scalar/vector data memory for the ASIP datapath. It implements the vector data path next to the existing scalar one. Storage is a single array of N-bit words. A scalar access touches one word. A vector access touches LANES consecutive words, serialized one word per cycle by an internal sequencer. Requests use a valid/ready handshake, and a one-cycle response pulse returns read data or acknowledges a write.

## Interface
Parameters:
- N, 24, scalar word width and address-bus width
- AW, 14, internal word-address width
- DEPTH, 2**AW (16384), number of N-bit words
- LANES, 8, words per vector; vector width is LANES*N

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_vector  in  1  1 = vector access, 0 = scalar access
- req_write  in  1  1 = write, 0 = read
- req_addr  in  N  word address; only bits [AW-1:0] are used
- req_wdata_s  in  N  scalar write data
- req_wdata_v  in  LANES*N  vector write data; lane i = bits [i*N +: N]
- req_mask  in  LANES  lane enables; present only with VMEM_LANE_MASK_EN
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata_s  out  N  scalar read data
- rsp_rdata_v  out  LANES*N  vector read data

## Operation
- A request is accepted on a rising edge where req_valid && req_ready. All request fields are captured on that edge.
- FSM states and transitions:
  - IDLE: req_ready=1. A scalar request is served in IDLE. A vector request moves to VBUSY.
  - VBUSY: req_ready=0. One lane per cycle, with a beat counter running 0..LANES-1. After the last beat, go to VRESP.
  - VRESP: rsp_valid=1 and req_ready=1, so a new request can be accepted in this cycle. Go to IDLE, or go straight back to VBUSY if a vector request is accepted.
- Scalar write:
  - Word written at the accepting edge.
  - rsp_valid pulses the next cycle as the write ack.
  - rsp_rdata_s holds its previous value.
- Scalar read: rsp_rdata_s = mem[addr] registered; rsp_valid pulses the next cycle.
- Vector access: lane i maps to word (addr+i) mod DEPTH. Addresses wrap around the end of the array.
  - Reads fill a lane buffer, which is presented on rsp_rdata_v.
  - Writes store lane i during beat i.
- Read-after-write to the same word in consecutive requests returns the new data.
- A request arriving while req_ready=0 is not accepted. The requester must hold it stable until accepted.
- Memory contents are not cleared by reset.

## Timing
- Scalar latency: rsp_valid 1 cycle after the accepting edge. Throughput is 1 request per cycle.
- Vector latency: rsp_valid exactly LANES+1 cycles after the accepting edge.
  - req_ready is low for LANES cycles.
  - The fixed latency holds regardless of the lane mask.
- Reset values: req_ready=0 while rst_n is low, then 1 from the first cycle after release. rsp_valid=0, rsp_rdata_s=0, rsp_rdata_v=0, state=IDLE, beat=0.
- Reset asserted mid-vector:
  - The FSM aborts immediately.
  - Lanes already written stay written.
  - No response is issued.
- rsp_rdata_* hold their values until the next read response.

## Configuration
- VMEM_LANE_MASK_EN defined:
  - req_mask port exists.
  - Vector writes skip lanes whose mask bit is 0; the beat is still consumed.
  - Vector reads return 0 in masked-off lanes.
  - Scalar accesses ignore the mask.
- VMEM_LANE_MASK_EN undefined: no req_mask port, and all lanes are always enabled.

## Structure
- Shared package vmem_pkg holds:
  - FSM state enum (IDLE, VBUSY, VRESP)
  - default N, AW and LANES constants
  - a lane-select function
- One sub-module, vmem_sp_ram: single-port synchronous RAM with DEPTH words of N bits, write enable, and registered read. The sequencer drives it.

## Test plan
Defaults for all scenarios: N=24, LANES=8.
- Scalar write 24'h00ABCD to addr 24'h0005, then read addr 5 on the next cycle: rsp_valid pulses after each request, and the read returns 24'h00ABCD.
- Vector write lanes 1..8 to addr 24'h0010, then vector read 24'h0010: rsp_valid comes 9 cycles after each accept, req_ready is low for 8 cycles, and the read returns lanes 1..8.
- Vector write at addr 24'h3FFC (DEPTH-4): lanes 4..7 land at words 0..3. A scalar read of addr 0 returns lane 4.
- With VMEM_LANE_MASK_EN, write with mask 8'b0101_0101 over a region prefilled with 0 and value 24'hFFFFFF in every lane: the vector read returns 24'hFFFFFF in even lanes and 0 in odd lanes.
- Pull rst_n low during beat 3 of a vector write:
  - outputs reach their reset values asynchronously;
  - no rsp_valid is issued;
  - words for lanes 0..2 hold the new data and lanes 3..7 hold the old data.
- Present a vector request during VRESP of a previous vector: it is accepted in that cycle with no idle gap.
